pwm_gen: RTL
============

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-low reset; clock and reset are named as in the codebase (clk, rst_n).
REQ-002 Ports SHALL be:
clk  in  1  peripheral clock
rst_n  in  1  synchronous active-low reset
count_val  in  16  current counter value from the upstream counter
period  in  16  counter period, same value the counter uses
pwm_en  in  1  output enable from register file
compare1  in  16  first compare value (register file)
compare2  in  16  second compare value (register file)
functions  in  2  bit1 = unaligned mode, bit0 = right-align (ignored when bit1 = 1)
pwm_out  out  1  registered PWM waveform
period_evt  out  1  one-cycle pulse on counter wrap

Function
REQ-003 The block SHALL hold shadow copies of compare1, compare2 and functions; all waveform decisions use only the shadow copies.
REQ-004 While pwm_en = 0, the shadows SHALL load the inputs every cycle, and pwm_out SHALL be 0.
REQ-005 While pwm_en = 1, the shadows SHALL load only in the cycle a wrap is detected; register writes at other times take effect at the next wrap.
REQ-006 The block SHALL register the previous count_val (prev_cnt); a wrap SHALL be detected when prev_cnt = period and count_val = 0 (up-count), or prev_cnt = 0 and count_val = period with period != 0 (down-count).
REQ-007 period_evt SHALL be 1 for exactly the cycle after a detected wrap, independent of pwm_en.
REQ-008 No wrap SHALL be detected when count_val equals prev_cnt (counter stalled by prescaler or disabled).
REQ-009 Left-aligned mode (functions = 00): the next pwm_out SHALL be 1 iff count_val < compare1.
REQ-010 Right-aligned mode (functions = 01): the next pwm_out SHALL be 1 iff count_val >= compare1.
REQ-011 Unaligned mode (functions = 1x): the next pwm_out SHALL be 1 iff compare1 <= count_val < compare2.
REQ-012 All comparisons SHALL be 16-bit unsigned.
REQ-013 pwm_out SHALL have a latency of exactly 1 clk from count_val.
REQ-014 Boundaries:
- compare1 = 0 in left mode: pwm_out constant 0.
- compare1 > period in left mode: pwm_out constant 1.
- compare1 = 0 in right mode: pwm_out constant 1.
- compare2 <= compare1 in unaligned mode: pwm_out constant 0.
REQ-015 When a wrap and a shadow load occur in the same cycle, the comparison for that cycle SHALL use the newly loaded values.
REQ-016 When pwm_en rises, the first pwm_out evaluation SHALL use the shadows loaded in the preceding disabled cycle.

Reset
REQ-017 While rst_n = 0 at a clk edge, the block SHALL set pwm_out = 0, period_evt = 0, prev_cnt = 0, and all shadows = 0.
REQ-018 A reset asserted mid-period SHALL take effect at the next clk edge with no partial pulse afterward.
REQ-019 After reset release, the first wrap SHALL NOT be detected until prev_cnt has been sampled from a real count_val.

Structure
REQ-020 A shared package SHALL hold the functions-field encodings FUNC_LEFT = 2'b00, FUNC_RIGHT = 2'b01, FUNC_UNALIGNED bit index 1, and the counter width constant CNT_W = 16.
REQ-021 Wrap detection (prev_cnt register, wrap compare and period_evt) SHALL be one sub-module named pwm_wrap_detect; shadows and compare logic stay in pwm_gen.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Left: period = 9, compare1 = 3, up-count -> pwm_out high for 3 of every 10 counts, lagging count_val by 1 clk.
- Right: period = 9, compare1 = 7 -> high for counts 7..9 (3 clks per period); compare1 = 0 -> constantly high.
- Unaligned: compare1 = 2, compare2 = 5 -> high for counts 2..4; then compare2 = 2 -> constantly 0 after the next wrap.
- Shadow: write compare1 3 -> 6 at count 4 with pwm_en = 1 -> the current period is unchanged, the next period is 6 high, and period_evt pulses once at the wrap.
- Down-count: period = 4 -> wrap detected on 0 -> 4 and period_evt pulses once per 5 counts; a stalled count (prescale = 2) gives no extra pulses.
- Reset at count 5 with pwm_out = 1 -> next cycle pwm_out = 0 and period_evt = 0, with no evt pulse on the first sample after release.

Source files
------------

// File: rtl/pwm_gen_pkg.sv
// Shared definitions for the PWM generator: counter width, the encodings of
// the 'functions' field, the shadow-register bundle and the waveform rule.
package pwm_gen_pkg;

    // Width of the counter value, period and compare registers.
    localparam int CNT_W = 16;

    // Encodings of the 2-bit functions field.
    localparam logic [1:0] FUNC_LEFT      = 2'b00;
    localparam logic [1:0] FUNC_RIGHT     = 2'b01;
    // When this bit is set the mode is unaligned and bit 0 is ignored.
    localparam int         FUNC_UNALIGNED = 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Register-file values copied into the block; the waveform only ever
    // looks at this copy, never at the live register-file inputs.
    typedef struct packed {
        cnt_t       compare1;
        cnt_t       compare2;
        logic [1:0] functions;
    } shadow_t;

    // Waveform level for one counter value under a given shadow set.
    // All comparisons are unsigned because cnt_t is an unsigned vector.
    function automatic logic pwm_level(input cnt_t cnt, input shadow_t sh);
        logic level;
        if (sh.functions[FUNC_UNALIGNED]) begin
            // Window [compare1, compare2); empty when compare2 <= compare1.
            level = (cnt >= sh.compare1) && (cnt < sh.compare2);
        end else if (sh.functions == FUNC_LEFT) begin
            // High at the start of the period, low from compare1 onward.
            level = (cnt < sh.compare1);
        end else begin
            // Right-aligned: low until compare1, high from there to the end.
            level = (cnt >= sh.compare1);
        end
        return level;
    endfunction

endpackage

// File: rtl/pwm_wrap_detect.sv
// Counter wrap detector. Remembers the previous counter value and flags the
// cycle in which the counter rolls over in either direction. The combinational
// 'wrap' is used by the parent to time shadow loads; 'period_evt' is the
// registered one-cycle event seen by the rest of the system.
module pwm_wrap_detect
    import pwm_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count_val,
    input  logic [CNT_W-1:0] period,
    output logic             wrap,
    output logic             period_evt
);

    logic [CNT_W-1:0] prev_cnt;
    // Set once prev_cnt holds a value actually sampled from the counter, so
    // the reset value of prev_cnt can never fake a down-count wrap.
    logic             prev_valid;

    logic up_wrap;
    logic down_wrap;
    logic moved;

    // Decode a rollover from the previous and current counter values.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path; the
        // plain assignments below are unconditional, so no latch can form.
        moved     = (count_val != prev_cnt);
        up_wrap   = (prev_cnt == period) && (count_val == '0);
        down_wrap = (prev_cnt == '0) && (count_val == period) && (period != '0);
        // A stalled counter (prescaler or disabled) never counts as a wrap,
        // which also covers period = 0 where both values sit at zero.
        wrap      = prev_valid && moved && (up_wrap || down_wrap);
    end

    // Track the previous counter value and register the wrap event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            prev_cnt   <= '0;
            prev_valid <= 1'b0;
            period_evt <= 1'b0;
        end else begin
            prev_cnt   <= count_val;
            prev_valid <= 1'b1;
            period_evt <= wrap;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM waveform generator driven by an external counter. Compare values and
// mode are double-buffered in shadow registers: while the output is disabled
// they follow the register file every cycle, while enabled they only update
// on a counter wrap so a period is never produced with mixed settings.
module pwm_gen
    import pwm_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count_val,
    input  logic [CNT_W-1:0] period,
    input  logic             pwm_en,
    input  logic [CNT_W-1:0] compare1,
    input  logic [CNT_W-1:0] compare2,
    input  logic [1:0]       functions,
    output logic             pwm_out,
    output logic             period_evt
);

    logic    wrap;
    logic    load;
    shadow_t shadow_q;
    shadow_t shadow_in;
    shadow_t shadow_eff;

    pwm_wrap_detect u_wrap_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_val  (count_val),
        .period     (period),
        .wrap       (wrap),
        .period_evt (period_evt)
    );

    // Select the shadow set this cycle's comparison uses.
    always_comb begin
        shadow_in.compare1  = compare1;
        shadow_in.compare2  = compare2;
        shadow_in.functions = functions;
        load                = !pwm_en || wrap;
        // On a load cycle the comparison already uses the freshly loaded
        // values, so the first count of a new period follows the new settings.
        shadow_eff          = load ? shadow_in : shadow_q;
    end

    // Shadow registers and the registered waveform output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (load) begin
                shadow_q <= shadow_in;
            end
            pwm_out <= pwm_en && pwm_level(count_val, shadow_eff);
        end
    end

endmodule
